// File: rtl/vpu_sequencer.sv
// Instruction sequencer for the 8-lane Q16.16 vector datapath: owns the vector
// register file, holds operands for an opcode-dependent time, writes results back.
module vpu_sequencer #(
    parameter int NUM_VREGS   = 8,
    parameter int EXEC_CYCLES = 1,
    parameter int DIV_CYCLES  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       instr_op,
    input  logic [2:0]       instr_rd,
    input  logic [2:0]       instr_ra,
    input  logic [2:0]       instr_rb,
    input  logic [31:0]      instr_scalar,
    output logic [7:0][31:0] dp_vec_a,
    output logic [7:0][31:0] dp_vec_b,
    output logic [31:0]      dp_scalar,
    output logic [2:0]       dp_operation,
    input  logic [7:0][31:0] dp_result,
    input  logic             host_wr_en,
    input  logic [2:0]       host_wr_reg,
    input  logic [2:0]       host_wr_lane,
    input  logic [31:0]      host_wr_data,
    input  logic [2:0]       host_rd_reg,
    input  logic [2:0]       host_rd_lane,
    output logic [31:0]      host_rd_data,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int MAX_CYCLES = (DIV_CYCLES > EXEC_CYCLES) ? DIV_CYCLES : EXEC_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       rd_r;
    logic [2:0]       ra_r;
    logic [2:0]       rb_r;
    logic [2:0]       dp_op_r;
    logic [31:0]      dp_scalar_r;
    logic             illegal_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic             err_defer_r;
    logic [31:0]      rf_r [NUM_VREGS][8];
    logic [31:0]      host_rd_data_r;

    logic             accept_s;
    logic             last_exec_s;
    logic             host_wr_ok_s;
    logic             host_busy_wr_s;

    assign instr_ready    = (state_r == IDLE) && !rst && !illegal_r;
    assign accept_s       = instr_valid && instr_ready;
    assign last_exec_s    = (state_r == EXEC) && (cnt_r == CNT_W'(1));
    assign host_wr_ok_s   = host_wr_en && (state_r == IDLE);
    assign host_busy_wr_s = host_wr_en && (state_r != IDLE);

    assign busy         = busy_r;
    assign done         = done_r;
    assign err          = err_r;
    assign dp_operation = dp_op_r;
    assign dp_scalar    = dp_scalar_r;
    assign host_rd_data = host_rd_data_r;

    // Control FSM: handshake, hold counter, done/err pulses and datapath opcode/scalar.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            rd_r        <= 3'd0;
            ra_r        <= 3'd0;
            rb_r        <= 3'd0;
            dp_op_r     <= 3'b111;
            dp_scalar_r <= 32'd0;
            illegal_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            err_defer_r <= 1'b0;
        end else begin
            done_r    <= 1'b0;
            illegal_r <= 1'b0;
            // A rejected host write landing on the done cycle is reported one cycle later.
            err_r       <= (host_busy_wr_s && !last_exec_s) || err_defer_r;
            err_defer_r <= host_busy_wr_s && last_exec_s;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        rd_r <= instr_rd;
                        ra_r <= instr_ra;
                        rb_r <= instr_rb;
                        if (instr_op >= 3'd5) begin
                            illegal_r <= 1'b1;
                            err_r     <= 1'b1;
                        end else begin
                            cnt_r       <= (instr_op == 3'b011) ? CNT_W'(DIV_CYCLES)
                                                                : CNT_W'(EXEC_CYCLES);
                            dp_op_r     <= instr_op;
                            dp_scalar_r <= instr_scalar;
                            busy_r      <= 1'b1;
                            state_r     <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (last_exec_s) begin
                        dp_op_r     <= 3'b111;
                        dp_scalar_r <= 32'd0;
                        done_r      <= 1'b1;
                        state_r     <= WB;
                    end
                end
                WB: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    dp_op_r     <= 3'b111;
                    dp_scalar_r <= 32'd0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    // Register file: write-back on the last EXEC edge, host writes only while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_VREGS; r++) begin
                for (int l = 0; l < 8; l++) begin
                    rf_r[r][l] <= 32'd0;
                end
            end
            host_rd_data_r <= 32'd0;
        end else begin
            host_rd_data_r <= rf_r[host_rd_reg][host_rd_lane];
            if (last_exec_s) begin
                for (int l = 0; l < 8; l++) begin
                    rf_r[rd_r][l] <= dp_result[l];
                end
            end else if (host_wr_ok_s) begin
                rf_r[host_wr_reg][host_wr_lane] <= host_wr_data;
            end
        end
    end

    // Operand vectors come straight from the register file while executing, zero otherwise.
    always_comb begin
        dp_vec_a = '0;
        dp_vec_b = '0;
        if (state_r == EXEC) begin
            for (int l = 0; l < 8; l++) begin
                dp_vec_a[l] = rf_r[ra_r][l];
                dp_vec_b[l] = rf_r[rb_r][l];
            end
        end else begin
            dp_vec_a = '0;
            dp_vec_b = '0;
        end
    end

endmodule

// File: tb/tb_vpu_sequencer.sv
// Bench for vpu_sequencer: behavioural datapath stub, vector table, corner
// sequences and a randomized run against a register-file reference model.
module tb_vpu_sequencer;

    localparam int EXEC_N = 1;
    localparam int DIV_N  = 4;

    logic             clk;
    logic             rst;
    logic             instr_valid;
    logic             instr_ready;
    logic [2:0]       instr_op, instr_rd, instr_ra, instr_rb;
    logic [31:0]      instr_scalar;
    logic [7:0][31:0] dp_vec_a, dp_vec_b, dp_result;
    logic [31:0]      dp_scalar;
    logic [2:0]       dp_operation;
    logic             host_wr_en;
    logic [2:0]       host_wr_reg, host_wr_lane, host_rd_reg, host_rd_lane;
    logic [31:0]      host_wr_data, host_rd_data;
    logic             busy, done, err;

    int vec_cnt = 0;
    int miss_cnt = 0;
    int hold_cnt = 0;
    logic [31:0] m_rf [8][8];

    vpu_sequencer #(.NUM_VREGS(8), .EXEC_CYCLES(EXEC_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_ra(instr_ra), .instr_rb(instr_rb),
        .instr_scalar(instr_scalar),
        .dp_vec_a(dp_vec_a), .dp_vec_b(dp_vec_b), .dp_scalar(dp_scalar),
        .dp_operation(dp_operation), .dp_result(dp_result),
        .host_wr_en(host_wr_en), .host_wr_reg(host_wr_reg), .host_wr_lane(host_wr_lane),
        .host_wr_data(host_wr_data), .host_rd_reg(host_rd_reg), .host_rd_lane(host_rd_lane),
        .host_rd_data(host_rd_data), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Q16.16 lane arithmetic as the datapath defines it
    function automatic logic [31:0] q_fn(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] s);
        logic [63:0] p;
        logic signed [63:0] n, d, q;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: begin
                p = {{32{a[31]}}, a} * {{32{s[31]}}, s};
                return p[47:16];
            end
            3'd3: begin
                if (s == 32'd0) return 32'd0;
                n = {{16{a[31]}}, a, 16'h0000};
                d = {{32{s[31]}}, s};
                q = n / d;
                return q[31:0];
            end
            3'd4: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Divider stub only settles after the operands have been held DIV_N cycles
    always @(posedge clk) hold_cnt <= (dp_operation == 3'b011) ? hold_cnt + 1 : 0;

    always_comb begin
        for (int l = 0; l < 8; l++) begin
            if (dp_operation == 3'b011 && hold_cnt < DIV_N - 1)
                dp_result[l] = 32'hBAD0BAD0;
            else
                dp_result[l] = q_fn(dp_operation, dp_vec_a[l], dp_vec_b[l], dp_scalar);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [2:0] r, input logic [2:0] l, input logic [31:0] d);
        host_wr_en = 1'b1; host_wr_reg = r; host_wr_lane = l; host_wr_data = d;
        cycle();
        host_wr_en = 1'b0;
        m_rf[r][l] = d;
    endtask

    task automatic host_read(input logic [2:0] r, input logic [2:0] l, output logic [31:0] d);
        host_rd_reg = r; host_rd_lane = l;
        cycle();
        d = host_rd_data;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!instr_ready && t < 50) begin cycle(); t++; end
        check("ready_timeout", 32'(instr_ready), 32'd1);
    endtask

    task automatic model_exec(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra,
                              input logic [2:0] rb, input logic [31:0] sc);
        for (int l = 0; l < 8; l++) m_rf[rd][l] = q_fn(op, m_rf[ra][l], m_rf[rb][l], sc);
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra,
                         input logic [2:0] rb, input logic [31:0] sc);
        int lat, opc, n;
        wait_ready();
        instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_ra = ra; instr_rb = rb;
        instr_scalar = sc;
        cycle();
        instr_valid = 1'b0;
        if (op >= 3'd5) begin
            check("illegal_err", 32'(err), 32'd1);
            check("illegal_ready_low", 32'(instr_ready), 32'd0);
            check("illegal_no_done", 32'(done), 32'd0);
            cycle();
            check("illegal_ready_back", 32'(instr_ready), 32'd1);
        end else begin
            n = (op == 3'b011) ? DIV_N : EXEC_N;
            lat = 1; opc = 0;
            while (!done && lat < 30) begin
                if (dp_operation == op) opc++;
                cycle(); lat++;
            end
            check("done_latency", 32'(lat), 32'(n + 1));
            check("op_hold_cycles", 32'(opc), 32'(n));
            check("no_err_at_done", 32'(err), 32'd0);
            model_exec(op, rd, ra, rb, sc);
            cycle();
            check("ready_after_wb", 32'(instr_ready), 32'd1);
            check("idle_dp_op", 32'(dp_operation), 32'd7);
        end
    endtask

    task automatic check_rf();
        logic [31:0] d;
        for (int r = 0; r < 8; r++)
            for (int l = 0; l < 8; l++) begin
                host_read(3'(r), 3'(l), d);
                check($sformatf("rf_v%0d_l%0d", r, l), d, m_rf[r][l]);
            end
    endtask

    typedef struct {
        logic [2:0]  op, rd, ra, rb;
        logic [31:0] sc, a, b, exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [31:0] d;
        int t, k, dcnt;
        logic [2:0] op;

        vecs[0] = '{3'd0, 3'd3, 3'd1, 3'd2, 32'h0,        32'h00010000, 32'h00020000, 32'h00030000};
        vecs[1] = '{3'd1, 3'd3, 3'd1, 3'd2, 32'h0,        32'h00010000, 32'h00030000, 32'hFFFE0000};
        vecs[2] = '{3'd2, 3'd4, 3'd1, 3'd2, 32'h00008000, 32'h00030000, 32'h0,        32'h00018000};
        vecs[3] = '{3'd3, 3'd4, 3'd1, 3'd2, 32'h00020000, 32'h00010000, 32'h0,        32'h00008000};
        vecs[4] = '{3'd4, 3'd5, 3'd1, 3'd2, 32'h0,        32'hFFFF0000, 32'h00010000, 32'h00000001};
        vecs[5] = '{3'd4, 3'd5, 3'd1, 3'd2, 32'h0,        32'h00010000, 32'hFFFF0000, 32'h00000000};
        vecs[6] = '{3'd2, 3'd6, 3'd1, 3'd2, 32'h00018000, 32'hFFFE0000, 32'h0,        32'hFFFD0000};
        vecs[7] = '{3'd3, 3'd6, 3'd1, 3'd2, 32'hFFFF0000, 32'h00030000, 32'h0,        32'hFFFD0000};
        vecs[8] = '{3'd5, 3'd6, 3'd1, 3'd2, 32'h0,        32'h00070000, 32'h00010000, 32'h0};
        vecs[9] = '{3'd7, 3'd3, 3'd1, 3'd2, 32'h0,        32'h00020000, 32'h00010000, 32'h0};

        for (int r = 0; r < 8; r++) for (int l = 0; l < 8; l++) m_rf[r][l] = 32'd0;
        rst = 1'b1; instr_valid = 1'b0; instr_op = 3'd0; instr_rd = 3'd0; instr_ra = 3'd0;
        instr_rb = 3'd0; instr_scalar = 32'd0; host_wr_en = 1'b0; host_wr_reg = 3'd0;
        host_wr_lane = 3'd0; host_wr_data = 32'd0; host_rd_reg = 3'd0; host_rd_lane = 3'd0;
        cycle(); cycle();
        check("rst_ready", 32'(instr_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rd_data", host_rd_data, 32'd0);
        check("rst_dp_op", 32'(dp_operation), 32'd7);
        check("rst_dp_scalar", dp_scalar, 32'd0);
        check("rst_dp_vec_a", dp_vec_a[0], 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(instr_ready), 32'd1);

        // Table-driven vectors
        for (int i = 0; i < 10; i++) begin
            for (int l = 0; l < 8; l++) host_write(vecs[i].ra, 3'(l), vecs[i].a);
            for (int l = 0; l < 8; l++) host_write(vecs[i].rb, 3'(l), vecs[i].b);
            issue(vecs[i].op, vecs[i].rd, vecs[i].ra, vecs[i].rb, vecs[i].sc);
            for (int l = 0; l < 8; l++) begin
                host_read(vecs[i].rd, 3'(l), d);
                check($sformatf("vec%0d_lane%0d", i, l), d,
                      (vecs[i].op >= 3'd5) ? m_rf[vecs[i].rd][l] : vecs[i].exp);
            end
        end

        // Dependent back-to-back: slt result feeds an add immediately
        for (int l = 0; l < 8; l++) host_write(3'd1, 3'(l), 32'hFFFF0000);
        for (int l = 0; l < 8; l++) host_write(3'd2, 3'(l), 32'h00010000);
        issue(3'd4, 3'd5, 3'd1, 3'd2, 32'd0);
        issue(3'd0, 3'd6, 3'd5, 3'd5, 32'd0);
        host_read(3'd6, 3'd0, d); check("dep_add_l0", d, 32'h00000002);
        host_read(3'd6, 3'd7, d); check("dep_add_l7", d, 32'h00000002);

        // Reset during the second EXEC cycle of a div
        wait_ready();
        instr_valid = 1'b1; instr_op = 3'd3; instr_rd = 3'd7; instr_ra = 3'd1; instr_rb = 3'd2;
        instr_scalar = 32'h00020000;
        cycle();
        instr_valid = 1'b0;
        cycle();
        check("mid_div_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(instr_ready), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);
        dcnt = 0;
        for (int c = 0; c < 8; c++) begin if (done) dcnt++; cycle(); end
        check("abort_no_done", 32'(dcnt), 32'd0);
        for (int r = 0; r < 8; r++) for (int l = 0; l < 8; l++) m_rf[r][l] = 32'd0;
        host_read(3'd7, 3'd0, d); check("abort_rd_zero", d, 32'd0);
        host_read(3'd1, 3'd0, d); check("abort_rf_cleared", d, 32'd0);

        // Host write while busy is rejected with an err pulse
        for (int l = 0; l < 8; l++) host_write(3'd1, 3'(l), 32'h00050000);
        wait_ready();
        instr_valid = 1'b1; instr_op = 3'd3; instr_rd = 3'd3; instr_ra = 3'd1; instr_rb = 3'd1;
        instr_scalar = 32'h00010000;
        cycle();
        instr_valid = 1'b0;
        host_wr_en = 1'b1; host_wr_reg = 3'd1; host_wr_lane = 3'd0; host_wr_data = 32'h12345678;
        cycle();
        host_wr_en = 1'b0;
        check("busy_wr_err", 32'(err), 32'd1);
        cycle();
        check("busy_wr_err_pulse", 32'(err), 32'd0);
        t = 0;
        while (!done && t < 20) begin cycle(); t++; end
        check("busy_wr_done", 32'(done), 32'd1);
        cycle();
        model_exec(3'd3, 3'd3, 3'd1, 3'd1, 32'h00010000);
        host_read(3'd1, 3'd0, d); check("busy_wr_ignored", d, 32'h00050000);
        host_read(3'd3, 3'd0, d); check("busy_wr_div_result", d, 32'h00050000);

        // Host write in the same cycle as the accept is visible to EXEC
        host_write(3'd2, 3'd2, 32'h00010000);
        wait_ready();
        instr_valid = 1'b1; instr_op = 3'd0; instr_rd = 3'd4; instr_ra = 3'd1; instr_rb = 3'd2;
        instr_scalar = 32'd0;
        host_wr_en = 1'b1; host_wr_reg = 3'd1; host_wr_lane = 3'd2; host_wr_data = 32'h00070000;
        cycle();
        instr_valid = 1'b0; host_wr_en = 1'b0;
        m_rf[1][2] = 32'h00070000;
        t = 0;
        while (!done && t < 20) begin cycle(); t++; end
        check("same_cycle_done", 32'(done), 32'd1);
        cycle();
        model_exec(3'd0, 3'd4, 3'd1, 3'd2, 32'd0);
        host_read(3'd4, 3'd2, d); check("same_cycle_wr_seen", d, 32'h00080000);
        check_rf();

        // Randomized traffic against the reference model
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 3);
            if (k == 0) begin
                host_write(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), $urandom);
            end else begin
                op = (k == 3) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 4));
                issue(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7)), $urandom);
            end
        end
        check_rf();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
